// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/DRAIN/HALTED control.
// Optional FETCH_PERF_CNT_EN adds saturating stall and flush counters.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pcSrc,
    input  logic [11:0] branchTarget,
    input  logic [18:0] inst,
    input  logic        halt,
    output logic [11:0] pc,
    output logic [18:0] ifidInst,
    output logic [11:0] ifidPC1,
    output logic        ifidValid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t      r_state, w_next_state;
    logic [11:0] r_pc, w_pc_next, w_pc_inc;
    logic [18:0] r_ifid_inst, w_inst_next;
    logic [11:0] r_ifid_pc1, w_pc1_next;
    logic        r_ifid_valid, w_valid_next;
    logic [2:0]  r_drain, w_drain_next;
    logic        r_halted;

    assign w_pc_inc = r_pc + 12'd1;

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_inst_next  = r_ifid_inst;
        w_pc1_next   = r_ifid_pc1;
        w_valid_next = r_ifid_valid;
        w_drain_next = r_drain;
        case (r_state)
            RUN: begin
                if (pcSrc) begin
                    w_pc_next    = branchTarget;
                    w_inst_next  = '0;
                    w_pc1_next   = '0;
                    w_valid_next = 1'b0;
                end else if (stall) begin
                    w_pc_next = r_pc;
                end else if (halt) begin
                    w_inst_next  = '0;
                    w_pc1_next   = '0;
                    w_valid_next = 1'b0;
                    w_drain_next = 3'd4;
                    w_next_state = DRAIN;
                end else begin
                    w_pc_next    = w_pc_inc;
                    w_inst_next  = inst;
                    w_pc1_next   = w_pc_inc;
                    w_valid_next = 1'b1;
                end
            end
            DRAIN: begin
                // An older branch still in EX overrides the halt seen in fetch.
                if (pcSrc) begin
                    w_pc_next    = branchTarget;
                    w_inst_next  = '0;
                    w_pc1_next   = '0;
                    w_valid_next = 1'b0;
                    w_drain_next = '0;
                    w_next_state = RUN;
                end else if (!stall) begin
                    w_drain_next = r_drain - 3'd1;
                    if (r_drain == 3'd1)
                        w_next_state = HALTED;
                end
            end
            HALTED: begin
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_pc         <= '0;
            r_ifid_inst  <= '0;
            r_ifid_pc1   <= '0;
            r_ifid_valid <= 1'b0;
            r_drain      <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_pc_next;
            r_ifid_inst  <= w_inst_next;
            r_ifid_pc1   <= w_pc1_next;
            r_ifid_valid <= w_valid_next;
            r_drain      <= w_drain_next;
            r_halted     <= (w_next_state == HALTED);
        end
    end

    assign pc        = r_pc;
    assign ifidInst  = r_ifid_inst;
    assign ifidPC1   = r_ifid_pc1;
    assign ifidValid = r_ifid_valid;
    assign halted    = r_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_stall_cnt, r_flush_cnt;
    logic        w_active;

    assign w_active = (r_state != HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (w_active) begin
            if (stall && !pcSrc && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (pcSrc && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stallCount = r_stall_cnt;
    assign flushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; counter checks compile in with FETCH_PERF_CNT_EN.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pcSrc = 1'b0;
    logic [11:0] branchTarget = '0;
    logic [18:0] inst = '0;
    logic        halt = 1'b0;
    logic [11:0] pc;
    logic [18:0] ifidInst;
    logic [11:0] ifidPC1;
    logic        ifidValid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stallCount, flushCount;
`endif

    int passed = 0;
    int total  = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .pcSrc(pcSrc),
        .branchTarget(branchTarget), .inst(inst), .halt(halt),
        .pc(pc), .ifidInst(ifidInst), .ifidPC1(ifidPC1),
        .ifidValid(ifidValid), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .stallCount(stallCount), .flushCount(flushCount)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++; if (pc !== 12'h000) $display("FAIL reset_pc: got %h want 000", pc); else passed++;
        total++; if (ifidInst !== 19'h0) $display("FAIL reset_inst: got %h want 0", ifidInst); else passed++;
        total++; if (ifidPC1 !== 12'h000) $display("FAIL reset_pc1: got %h want 000", ifidPC1); else passed++;
        total++; if (ifidValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifidValid); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
`ifdef FETCH_PERF_CNT_EN
        total++; if (stallCount !== 16'd0 || flushCount !== 16'd0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stallCount, flushCount); else passed++;
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [18:0] v;
        total++; if (pc !== 12'h000) $display("FAIL seq_pc0: got %h want 000", pc); else passed++;
        for (int k = 1; k <= 3; k++) begin
            v = 19'h40321 ^ 19'(k);
            inst = v;
            step();
            total++; if (pc !== 12'(k)) $display("FAIL seq_pc: got %h want %h", pc, 12'(k)); else passed++;
            total++; if (ifidPC1 !== 12'(k)) $display("FAIL seq_pc1: got %h want %h", ifidPC1, 12'(k)); else passed++;
            total++; if (ifidValid !== 1'b1) $display("FAIL seq_valid: got %b want 1", ifidValid); else passed++;
            total++; if (ifidInst !== v) $display("FAIL seq_inst: got %h want %h", ifidInst, v); else passed++;
        end
    endtask

    task automatic test_stall();
        inst = 19'h11111; step();
        inst = 19'h22222; step();
        total++; if (pc !== 12'h005) $display("FAIL stall_setup_pc: got %h want 005", pc); else passed++;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            inst = 19'h7ABCD ^ 19'(k);
            step();
            total++; if (pc !== 12'h005) $display("FAIL stall_pc: got %h want 005", pc); else passed++;
            total++; if (ifidInst !== 19'h22222) $display("FAIL stall_inst: got %h want 22222", ifidInst); else passed++;
            total++; if (ifidPC1 !== 12'h005) $display("FAIL stall_pc1: got %h want 005", ifidPC1); else passed++;
        end
        stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        total++; if (stallCount !== 16'd2) $display("FAIL stall_count: got %0d want 2", stallCount); else passed++;
`endif
    endtask

    task automatic test_branch();
        inst = 19'h00005; step();
        inst = 19'h00006; step();
        total++; if (pc !== 12'h007) $display("FAIL br_setup_pc: got %h want 007", pc); else passed++;
        pcSrc = 1'b1; stall = 1'b1; branchTarget = 12'h0A0; inst = 19'h12345;
        step();
        pcSrc = 1'b0; stall = 1'b0;
        total++; if (pc !== 12'h0A0) $display("FAIL br_pc: got %h want 0a0", pc); else passed++;
        total++; if (ifidValid !== 1'b0) $display("FAIL br_valid: got %b want 0", ifidValid); else passed++;
        total++; if (ifidInst !== 19'h0 || ifidPC1 !== 12'h0)
            $display("FAIL br_flush: got %h/%h want 0/0", ifidInst, ifidPC1); else passed++;
`ifdef FETCH_PERF_CNT_EN
        total++; if (flushCount !== 16'd1 || stallCount !== 16'd2)
            $display("FAIL br_counters: got flush %0d stall %0d want 1 2", flushCount, stallCount); else passed++;
`endif
    endtask

    task automatic test_wrap();
        pcSrc = 1'b1; branchTarget = 12'hFFF; step(); pcSrc = 1'b0;
        total++; if (pc !== 12'hFFF) $display("FAIL wrap_setup: got %h want fff", pc); else passed++;
        inst = 19'h5A5A5; step();
        total++; if (pc !== 12'h000) $display("FAIL wrap_pc: got %h want 000", pc); else passed++;
        total++; if (ifidPC1 !== 12'h000) $display("FAIL wrap_pc1: got %h want 000", ifidPC1); else passed++;
        total++; if (ifidValid !== 1'b1 || ifidInst !== 19'h5A5A5)
            $display("FAIL wrap_ifid: got %b/%h want 1/5a5a5", ifidValid, ifidInst); else passed++;
    endtask

    task automatic test_halt_branch();
        pcSrc = 1'b1; branchTarget = 12'h009; step(); pcSrc = 1'b0;
        halt = 1'b1; inst = 19'h0; step(); halt = 1'b0;
        total++; if (pc !== 12'h009) $display("FAIL hb_pc_hold: got %h want 009", pc); else passed++;
        step();
        pcSrc = 1'b1; branchTarget = 12'h020; step(); pcSrc = 1'b0;
        total++; if (pc !== 12'h020) $display("FAIL hb_pc: got %h want 020", pc); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL hb_halted: got %b want 0", halted); else passed++;
        inst = 19'h00777; step();
        total++; if (pc !== 12'h021 || ifidValid !== 1'b1)
            $display("FAIL hb_run: got pc %h valid %b want 021 1", pc, ifidValid); else passed++;
    endtask

    task automatic test_halt();
        pcSrc = 1'b1; branchTarget = 12'h009; step(); pcSrc = 1'b0;
        halt = 1'b1; inst = 19'h0; step(); halt = 1'b0;
        total++; if (pc !== 12'h009 || ifidValid !== 1'b0)
            $display("FAIL halt_enter: got pc %h valid %b want 009 0", pc, ifidValid); else passed++;
        for (int k = 2; k <= 4; k++) begin
            step();
            total++; if (halted !== 1'b0) $display("FAIL halt_early: edge %0d got %b want 0", k, halted); else passed++;
        end
        step();
        total++; if (halted !== 1'b1) $display("FAIL halt_rise: got %b want 1", halted); else passed++;
        pcSrc = 1'b1; stall = 1'b1; branchTarget = 12'h055; inst = 19'h3;
        step(); step();
        pcSrc = 1'b0; stall = 1'b0;
        total++; if (pc !== 12'h009 || halted !== 1'b1 || ifidValid !== 1'b0)
            $display("FAIL halt_frozen: got pc %h halted %b valid %b want 009 1 0", pc, halted, ifidValid); else passed++;
`ifdef FETCH_PERF_CNT_EN
        total++; if (flushCount !== 16'd5 || stallCount !== 16'd2)
            $display("FAIL halt_counters: got flush %0d stall %0d want 5 2", flushCount, stallCount); else passed++;
`endif
    endtask

    task automatic test_reset_halted();
        rst = 1'b1;
        #2;
        total++; if (halted !== 1'b0 || pc !== 12'h000)
            $display("FAIL rst_halted: got halted %b pc %h want 0 000", halted, pc); else passed++;
        @(negedge clk);
        rst = 1'b0; inst = 19'h40321;
        step();
        total++; if (pc !== 12'h001 || ifidPC1 !== 12'h001 || ifidValid !== 1'b1)
            $display("FAIL rst_refetch: got pc %h pc1 %h valid %b want 001 001 1", pc, ifidPC1, ifidValid); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_wrap();
        test_halt_branch();
        test_halt();
        test_reset_halted();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
